// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the two raw sensors, emits one coin
// code per physical coin, and keeps a saturating credit tally plus a sticky jam flag.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 8,
    parameter int JAM_CYCLES      = 64,
    parameter int CREDIT_W        = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_sense5,
    input  logic                i_sense10,
    input  logic                i_accept_en,
    output logic [1:0]          o_coin,
    output logic                o_reject,
    output logic                o_busy,
    output logic                o_jam,
    output logic [CREDIT_W-1:0] o_credit_total
);
    localparam int CNT_M1  = (DEBOUNCE_CYCLES > LOCKOUT_CYCLES) ? DEBOUNCE_CYCLES : LOCKOUT_CYCLES;
    localparam int CNT_MAX = (CNT_M1 > JAM_CYCLES) ? CNT_M1 : JAM_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DEB_N     = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] JAM_LAST  = CNT_W'(JAM_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_WAIT_RELEASE,
        S_LOCKOUT,
        S_JAM
    } state_t;

    logic [1:0]          r_sync1, r_s;
    state_t              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic [1:0]          r_cand, w_cand_next;
    logic [1:0]          w_coin_next;
    logic                w_reject_next;
    logic [1:0]          r_coin;
    logic                r_reject, r_busy, r_jam;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W-1:0] w_credit_next;

    always_comb begin
        w_next        = r_state;
        w_cnt_next    = r_cnt;
        w_cand_next   = r_cand;
        w_coin_next   = 2'b00;
        w_reject_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_s != 2'b00 && i_accept_en) begin
                    w_cand_next = r_s;
                    w_cnt_next  = CNT_ONE;
                    w_next      = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (!i_accept_en) begin
                    w_next     = S_WAIT_RELEASE;
                    w_cnt_next = '0;
                end else if (r_s == r_cand) begin
                    if (r_cnt == DEB_N) begin
                        w_next     = S_WAIT_RELEASE;
                        w_cnt_next = '0;
                        // cand is never 00 here, so it doubles as the coin code
                        if (r_cand == 2'b11) w_reject_next = 1'b1;
                        else                 w_coin_next   = r_cand;
                    end else begin
                        w_cnt_next = r_cnt + CNT_ONE;
                    end
                end else if (r_s == 2'b00) begin
                    w_next     = S_IDLE;
                    w_cnt_next = '0;
                end else begin
                    w_cand_next = r_s;
                    w_cnt_next  = CNT_ONE;
                end
            end
            S_WAIT_RELEASE: begin
                if (r_s == 2'b00) begin
                    w_next     = S_LOCKOUT;
                    w_cnt_next = '0;
                end else if (r_cnt == JAM_LAST) begin
                    w_next = S_JAM;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            S_LOCKOUT: begin
                if (r_cnt == LOCK_LAST) begin
                    w_next     = S_IDLE;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            S_JAM:   w_next = S_JAM;
            default: w_next = S_IDLE;
        endcase
    end

    // coin code 01/10 equals its value in 5-yuan units
    assign w_sum         = {1'b0, r_credit} + (CREDIT_W+1)'(w_coin_next);
    assign w_credit_next = w_sum[CREDIT_W] ? '1 : w_sum[CREDIT_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= 2'b00;
            r_s      <= 2'b00;
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_cand   <= 2'b00;
            r_coin   <= 2'b00;
            r_reject <= 1'b0;
            r_busy   <= 1'b0;
            r_jam    <= 1'b0;
            r_credit <= '0;
        end else begin
            r_sync1  <= {i_sense10, i_sense5};
            r_s      <= r_sync1;
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_cand   <= w_cand_next;
            r_coin   <= w_coin_next;
            r_reject <= w_reject_next;
            r_busy   <= (w_next != S_IDLE);
            r_jam    <= r_jam | (w_next == S_JAM);
            r_credit <= w_credit_next;
        end
    end

    assign o_coin         = r_coin;
    assign o_reject       = r_reject;
    assign o_busy         = r_busy;
    assign o_jam          = r_jam;
    assign o_credit_total = r_credit;
endmodule
